// File: rtl/clkhz_gen4_pkg.sv
// Shared defaults and helpers for the four-rate game clock source.
// The board-level defaults are reused by the level mux and the game FSM.
package clkhz_gen4_pkg;

    localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEF_BASE_HZ     = 1;
    localparam int unsigned PH_W            = 4;

    // Prescaler terminal count: half of the fastest output period, truncated.
    function automatic int unsigned calc_half(input int unsigned clk_hz,
                                              input int unsigned base_hz);
        return clk_hz / (base_hz * 16);
    endfunction

    // RISE bit n follows phase bit (3-n), so the slowest output maps to the MSB of ph.
    function automatic logic [PH_W-1:0] rise_bits(input logic [PH_W-1:0] ph_cur,
                                                  input logic [PH_W-1:0] ph_nxt);
        logic [PH_W-1:0] r;
        r = '0;
        for (int n = 0; n < PH_W; n++) begin
            r[n] = ~ph_cur[PH_W-1-n] & ph_nxt[PH_W-1-n];
        end
        return r;
    endfunction

endpackage

// File: rtl/clkhz_gen4_tick_gen.sv
// Prescaler for clkhz_gen4: free-running 0..HALF-1 counter with a one-cycle
// TICK_o at the terminal count while enabled.
module tick_gen #(
    parameter int unsigned HALF = 2
) (
    input  logic CLK_i,
    input  logic RST_n_i,
    input  logic EN_i,
    input  logic SYNC_i,
    output logic TICK_o
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (HALF < 2) begin : g_bad_half
        $error("tick_gen: HALF must be at least 2");
    end

    logic [CW-1:0] pre_q, pre_d;
    logic          at_last;

    assign at_last = (pre_q == LAST);
    assign TICK_o  = EN_i & ~SYNC_i & at_last;

    always_comb begin
        pre_d = pre_q;
        if (SYNC_i) begin
            pre_d = '0;
        end else if (EN_i) begin
            pre_d = at_last ? '0 : pre_q + CW'(1);
        end
    end

    always_ff @(posedge CLK_i or negedge RST_n_i) begin
        if (!RST_n_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/clkhz_gen4.sv
// Four phase-aligned square waves at BASE_HZ*1/2/4/8 from the board clock, plus
// registered one-cycle rise pulses for logic that wants enables instead of clocks.
module clkhz_gen4
    import clkhz_gen4_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BASE_HZ     = DEF_BASE_HZ
) (
    input  logic       CLK_i,
    input  logic       RST_n_i,
    input  logic       EN_i,
    input  logic       SYNC_i,
    output logic       CL0_o,
    output logic       CL1_o,
    output logic       CL2_o,
    output logic       CL3_o,
    output logic [3:0] RISE_o
);

    localparam int unsigned HALF = calc_half(CLK_FREQ_HZ, BASE_HZ);

    logic            tick;
    logic [PH_W-1:0] ph_q, ph_d, ph_inc;
    logic [3:0]      rise_q, rise_d;

    tick_gen #(
        .HALF (HALF)
    ) u_tick_gen (
        .CLK_i   (CLK_i),
        .RST_n_i (RST_n_i),
        .EN_i    (EN_i),
        .SYNC_i  (SYNC_i),
        .TICK_o  (tick)
    );

    assign ph_inc = ph_q + PH_W'(1);

    // tick is already gated by EN_i and SYNC_i, so a frozen cycle just holds ph.
    always_comb begin
        ph_d   = ph_q;
        rise_d = '0;
        if (SYNC_i) begin
            ph_d = '0;
        end else if (tick) begin
            ph_d   = ph_inc;
            rise_d = rise_bits(ph_q, ph_inc);
        end
    end

    always_ff @(posedge CLK_i or negedge RST_n_i) begin
        if (!RST_n_i) begin
            ph_q   <= '0;
            rise_q <= '0;
        end else begin
            ph_q   <= ph_d;
            rise_q <= rise_d;
        end
    end

    assign CL3_o  = ph_q[0];
    assign CL2_o  = ph_q[1];
    assign CL1_o  = ph_q[2];
    assign CL0_o  = ph_q[3];
    assign RISE_o = rise_q;

endmodule

// File: tb/tb_clkhz_gen4.sv
// Scoreboarded bench for clkhz_gen4 with HALF=10: expected rise events are queued
// by the stimulus, and a monitor pops and compares whenever RISE_o is non-zero.
module tb_clkhz_gen4;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] cl;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i = 1'b1;
    logic       sync_i = 1'b0;
    logic       cl0, cl1, cl2, cl3;
    logic [3:0] rise;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   win_lo = 0;
    int   win_hi = -1;
    int   rise_cnt [4];
    exp_t sb_q [$];

    clkhz_gen4 #(
        .CLK_FREQ_HZ (160),
        .BASE_HZ     (1)
    ) dut (
        .CLK_i   (clk_i),
        .RST_n_i (rst_n_i),
        .EN_i    (en_i),
        .SYNC_i  (sync_i),
        .CL0_o   (cl0),
        .CL1_o   (cl1),
        .CL2_o   (cl2),
        .CL3_o   (cl3),
        .RISE_o  (rise)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [3:0] cl_vec();
        return {cl3, cl2, cl1, cl0};
    endfunction

    // CLn shows phase bit (3-n).
    function automatic logic [3:0] cl_of_ph(input logic [3:0] ph);
        return {ph[0], ph[1], ph[2], ph[3]};
    endfunction

    // On an increment the only 0->1 phase bit is the lowest set bit of the new value.
    function automatic logic [3:0] rise_of_ph(input logic [3:0] ph);
        logic [3:0] r;
        r = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            if (ph[b]) r = 4'b0001 << (3 - b);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_ph(input int c, input logic [3:0] ph);
        exp_t e;
        if (ph != 4'h0) begin
            e.cyc  = c;
            e.rise = rise_of_ph(ph);
            e.cl   = cl_of_ph(ph);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 5000) begin
            @(negedge clk_i);
            guard++;
        end
        if (cyc < c) chk("wait_timeout", cyc, c);
    endtask

    task automatic monitor();
        logic [3:0] prev;
        logic [3:0] cl;
        exp_t       e;
        prev = 4'b0000;
        forever begin
            @(negedge clk_i);
            cl = cl_vec();
            if (rst_n_i) begin
                chk("rise_coincident", int'(rise), int'(cl & ~prev));
                if (rise != 4'b0000) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_rise", int'(rise), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_cycle", cyc, e.cyc);
                        chk("sb_rise", int'(rise), int'(e.rise));
                        chk("sb_cl", int'(cl), int'(e.cl));
                    end
                end
                if (cyc > win_lo && cyc <= win_hi) begin
                    for (int n = 0; n < 4; n++) begin
                        if (cl[n] && !prev[n]) rise_cnt[n]++;
                    end
                end
            end
            prev = cl;
        end
    endtask

    initial begin
        int b0;
        int b1;
        for (int n = 0; n < 4; n++) rise_cnt[n] = 0;
        fork
            monitor();
        join_none

        // Reset held
        repeat (3) @(negedge clk_i);
        chk("reset_cl", int'(cl_vec()), 0);
        chk("reset_rise", int'(rise), 0);

        // Release between edges; edge b0+10k produces phase k
        rst_n_i = 1'b1;
        b0 = cyc;
        win_lo = b0;
        win_hi = b0 + 320;
        for (int k = 1; k <= 37; k++) push_ph(b0 + 10 * k, 4'(k % 16));

        wait_until(b0 + 9);
        chk("cl3_before_first", int'(cl3), 0);
        wait_until(b0 + 10);
        chk("first_cl3", int'(cl3), 1);
        chk("first_rise", int'(rise), 4'b1000);
        wait_until(b0 + 11);
        chk("rise_one_cycle", int'(rise), 0);
        wait_until(b0 + 20);
        chk("cl3_toggle", int'(cl3), 0);
        wait_until(b0 + 79);
        chk("cl0_before_80", int'(cl0), 0);
        wait_until(b0 + 80);
        chk("cl0_at_80", int'(cl0), 1);
        wait_until(b0 + 160);
        chk("cl0_at_160", int'(cl0), 0);
        wait_until(b0 + 321);
        chk("cnt_cl0", rise_cnt[0], 2);
        chk("cnt_cl1", rise_cnt[1], 4);
        chk("cnt_cl2", rise_cnt[2], 8);
        chk("cnt_cl3", rise_cnt[3], 16);

        // Freeze at ph=5, pre=4 for 37 edges
        wait_until(b0 + 374);
        en_i = 1'b0;
        for (int c = b0 + 375; c <= b0 + 411; c++) begin
            wait_until(c);
            chk("frozen_cl", int'(cl_vec()), int'(cl_of_ph(4'h5)));
            chk("frozen_rise", int'(rise), 0);
        end
        en_i = 1'b1;
        for (int k = 6; k <= 11; k++) push_ph(b0 + 417 + 10 * (k - 6), 4'(k));
        wait_until(b0 + 416);
        chk("resume_no_tick", int'(cl_vec()), int'(cl_of_ph(4'h5)));
        wait_until(b0 + 417);
        chk("resume_tick", int'(cl_vec()), int'(cl_of_ph(4'h6)));

        // SYNC at ph=B with EN low
        wait_until(b0 + 467);
        chk("ph_b", int'(cl_vec()), int'(cl_of_ph(4'hB)));
        en_i   = 1'b0;
        sync_i = 1'b1;
        wait_until(b0 + 468);
        chk("sync_cl", int'(cl_vec()), 0);
        chk("sync_rise", int'(rise), 0);
        sync_i = 1'b0;
        wait_until(b0 + 472);
        chk("sync_hold_cl", int'(cl_vec()), 0);
        en_i = 1'b1;
        for (int k = 1; k <= 15; k++) push_ph(b0 + 472 + 10 * k, 4'(k));

        wait_until(b0 + 552);
        chk("ph8_rise", int'(rise), 4'b0001);
        chk("ph8_cl", int'(cl_vec()), 4'b0001);
        wait_until(b0 + 632);
        chk("wrap_rise", int'(rise), 0);
        chk("wrap_cl", int'(cl_vec()), 0);
        wait_until(b0 + 636);
        chk("sb_drained", sb_q.size(), 0);

        // Asynchronous reset between edges, mid-count
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("async_cl", int'(cl_vec()), 0);
        chk("async_rise", int'(rise), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        b1 = cyc;
        for (int k = 1; k <= 8; k++) push_ph(b1 + 10 * k, 4'(k));
        wait_until(b1 + 10);
        chk("restart_cl3", int'(cl3), 1);
        wait_until(b1 + 80);
        chk("restart_cl0", int'(cl0), 1);
        wait_until(b1 + 85);
        chk("sb_final_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
